// File: rtl/lab2_proc_mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed
// latency, then answers from a word-addressed store with byte-lane access.
module lab2_proc_mem_responder #(
    parameter int p_mem_words = 256,
    parameter int p_latency   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    input  logic [76:0] reqstream_msg,
    output logic        respstream_val,
    input  logic        respstream_rdy,
    output logic [46:0] respstream_msg
);
    localparam int AW = $clog2(p_mem_words);
    localparam logic [3:0] LAT = 4'(p_latency);

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    req_t        req_q, req_in, wr_req;
    resp_t       resp;
    logic        req_xfer, resp_xfer, load, enter_resp, wr_en;

    logic [31:0] mem [p_mem_words];

    logic [AW-1:0]   wr_idx;
    logic [1:0]      wr_off, rd_off;
    logic [2:0]      wr_n, rd_n;
    logic [3:0][7:0] wr_cur, wr_src, wr_word, rd_word, rd_bytes;
    logic            unused_bits;

    assign req_in         = reqstream_msg;
    assign reqstream_rdy  = reset && (state == IDLE || (state == RESP && respstream_rdy));
    assign respstream_val = (state == RESP);
    assign req_xfer       = reqstream_val && reqstream_rdy;
    assign resp_xfer      = respstream_val && respstream_rdy;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        load       = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (req_xfer) load = 1'b1;
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: if (resp_xfer) begin
                if (req_xfer) load = 1'b1;
                else          state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A newly accepted request either waits out the latency or answers next cycle
        if (load) begin
            if (LAT == 4'd0) begin
                state_n    = RESP;
                enter_resp = 1'b1;
            end else begin
                state_n = WAIT;
                cnt_n   = LAT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) req_q <= req_in;
        end
    end

    // Storage commits on RESP entry; the request is still on the input when latency is zero
    assign wr_req = (state == WAIT) ? req_q : req_in;
    assign wr_idx = wr_req.addr[AW+1:2];
    assign wr_off = wr_req.addr[1:0];
    assign wr_n   = (wr_req.len == 2'd0) ? 3'd4 : {1'b0, wr_req.len};
    assign wr_cur = mem[wr_idx];
    assign wr_src = wr_req.data;
    assign wr_en  = enter_resp && reset && (wr_req.typ == 3'd1 || wr_req.typ == 3'd2);

    assign rd_word = mem[req_q.addr[AW+1:2]];
    assign rd_off  = req_q.addr[1:0];
    assign rd_n    = (req_q.len == 2'd0) ? 3'd4 : {1'b0, req_q.len};

    for (genvar b = 0; b < 4; b++) begin : g_lane
        localparam logic [2:0] B = 3'(b);
        logic [1:0] src_sel;
        logic [2:0] rd_pos;
        assign src_sel = 2'(b) - wr_off;
        assign rd_pos  = B + {1'b0, rd_off};
        // Lanes shifted past byte 3 are dropped on write and zero-filled on read
        assign wr_word[b]  = (B >= {1'b0, wr_off} && B < {1'b0, wr_off} + wr_n) ?
                             wr_src[src_sel] : wr_cur[b];
        assign rd_bytes[b] = (rd_pos < 3'd4 && B < rd_n) ? rd_word[rd_pos[1:0]] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

    always_comb begin
        resp        = '0;
        resp.typ    = req_q.typ;
        resp.opaque = req_q.opaque;
        resp.len    = req_q.len;
        if (state == RESP && !(req_q.typ == 3'd1 || req_q.typ == 3'd2)) resp.data = rd_bytes;
    end

    assign respstream_msg = resp;

    assign unused_bits = ^{wr_req.addr[31:AW+2], wr_req.opaque, req_q.addr[31:AW+2]};

endmodule
